// File: rtl/cpu_pkg.sv
// Shared datapath definitions: word/index widths, fixed register indices and
// the typedefs used by the register file, MXRegDst and the control unit.
package cpu_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    typedef logic [ADDR_W-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0] word_t;

    localparam reg_idx_t REG_ZERO = 5'd0;
    localparam reg_idx_t REG_RA   = 5'd31;

endpackage

// File: rtl/reg_file.sv
// 32-entry MIPS register file: two combinational read ports, one write port.
// Define REG_FILE_BYPASS_EN for write-through forwarding to same-cycle reads.
module reg_file
    import cpu_pkg::*;
#(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W
) (
    input  logic              CLK,
    input  logic              RST_n,
    input  logic              RegWre,
    input  logic [ADDR_W-1:0] WriteReg,
    input  logic [DATA_W-1:0] WriteData,
    input  logic [ADDR_W-1:0] ReadReg1,
    input  logic [ADDR_W-1:0] ReadReg2,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] IDX_ZERO = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] regs [DEPTH];
    logic              wr_en;
    logic              fwd1;
    logic              fwd2;

    // $0 is hard-wired: a write aimed at it never reaches storage.
    assign wr_en = RegWre && (WriteReg != IDX_ZERO);

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[WriteReg] <= WriteData;
        end
    end

`ifdef REG_FILE_BYPASS_EN
    // Forwarding is suppressed under reset so reads stay 0 while RST_n is low.
    assign fwd1 = RST_n && wr_en && (ReadReg1 == WriteReg);
    assign fwd2 = RST_n && wr_en && (ReadReg2 == WriteReg);
`else
    assign fwd1 = 1'b0;
    assign fwd2 = 1'b0;
`endif

    always_comb begin
        ReadData1 = '0;
        if (ReadReg1 != IDX_ZERO) begin
            ReadData1 = fwd1 ? WriteData : regs[ReadReg1];
        end
    end

    always_comb begin
        ReadData2 = '0;
        if (ReadReg2 != IDX_ZERO) begin
            ReadData2 = fwd2 ? WriteData : regs[ReadReg2];
        end
    end

endmodule
